// File: rtl/ctrl_camera_fsm.sv
// ctrl_camera_fsm: main camera sequencer.
// One trigger runs one frame: erase (idle), expose for the latched EXtime,
// then read row 1 and row 2 through the shared ADC. Moore machine; every
// output is decoded from the registered state only.
`timescale 1ns/1ps
module ctrl_camera_fsm #(
  parameter int EXP_W      = 5,
  parameter int ADC_CYCLES = 2
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Init,
  input  logic [EXP_W-1:0] EXtime,
  output logic             Erase,
  output logic             Expose,
  output logic             NRE_1,
  output logic             NRE_2,
  output logic             ADC,
  output logic             Busy,
  output logic             Frame_done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] EXPOSE = 3'd1;
  localparam logic [2:0] R1_SEL = 3'd2;
  localparam logic [2:0] R1_ADC = 3'd3;
  localparam logic [2:0] R1_REL = 3'd4;
  localparam logic [2:0] R2_SEL = 3'd5;
  localparam logic [2:0] R2_ADC = 3'd6;
  localparam logic [2:0] R2_REL = 3'd7;

  localparam logic [EXP_W-1:0] EXP_ZERO = '0;
  localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       ADC_LOAD = 4'(ADC_CYCLES);

  logic [2:0]       state;
  logic [EXP_W-1:0] exp_cnt;
  logic [3:0]       adc_cnt;

  // State sequencing plus the exposure and ADC down-counters; each counter
  // holds the cycles remaining in its state, so the last cycle is when it reads 1.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      exp_cnt <= EXP_ZERO;
      adc_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (Init) begin
            state   <= EXPOSE;
            exp_cnt <= (EXtime == EXP_ZERO) ? EXP_ONE : EXtime;
          end
        end
        EXPOSE: begin
          if (exp_cnt <= EXP_ONE) begin
            state   <= R1_SEL;
            exp_cnt <= EXP_ZERO;
          end else begin
            exp_cnt <= exp_cnt - EXP_ONE;
          end
        end
        R1_SEL: begin
          state   <= R1_ADC;
          adc_cnt <= ADC_LOAD;
        end
        R1_ADC: begin
          if (adc_cnt <= 4'd1) begin
            state   <= R1_REL;
            adc_cnt <= 4'd0;
          end else begin
            adc_cnt <= adc_cnt - 4'd1;
          end
        end
        R1_REL: state <= R2_SEL;
        R2_SEL: begin
          state   <= R2_ADC;
          adc_cnt <= ADC_LOAD;
        end
        R2_ADC: begin
          if (adc_cnt <= 4'd1) begin
            state   <= R2_REL;
            adc_cnt <= 4'd0;
          end else begin
            adc_cnt <= adc_cnt - 4'd1;
          end
        end
        R2_REL: state <= IDLE;
        default: begin
          state   <= IDLE;
          exp_cnt <= EXP_ZERO;
          adc_cnt <= 4'd0;
        end
      endcase
    end
  end

  assign Erase      = (state == IDLE);
  assign Expose     = (state == EXPOSE);
  assign NRE_1      = !((state == R1_SEL) || (state == R1_ADC));
  assign NRE_2      = !((state == R2_SEL) || (state == R2_ADC));
  assign ADC        = (state == R1_ADC) || (state == R2_ADC);
  assign Busy       = (state != IDLE);
  assign Frame_done = (state == R2_REL);

endmodule
